// File: rtl/snn_aer_pkg.sv
// Shared types and defaults for the AER spike output stage.
//   aer_state_t     : 4-phase handshake controller states
//   AER_ADDR_BITS   : default event address width (pixel index)
//   AER_SYNC_STAGES : default depth of the AEROUT_ACK synchronizer
package snn_aer_pkg;

  localparam int unsigned AER_ADDR_BITS   = 8;
  localparam int unsigned AER_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } aer_state_t;

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous FIFO that buffers sorted pixel indices ahead of the AER transmitter.
// Depth must be a power of two so the read/write pointers wrap for free.
// A push to a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   push     : write wdata this cycle (ignored when full and not popping)
//   pop      : remove the head entry this cycle (ignored when empty)
//   wdata    : entry to write
//   head     : current head entry
//   count    : number of stored entries (0..DEPTH)
//   full     : count == DEPTH
//   empty    : count == 0
module aer_event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // "Full" is judged after the pop, so a simultaneous pop frees the slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count marks them valid.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/aer_spike_out.sv
// AER spike output stage: buffers sorted pixel indices from the intensity sorter
// and sends each one to the SNN core with a 4-phase REQ/ACK handshake.
// Ports:
//   CLK, RST    : clock (rising edge), asynchronous active-high reset
//   EVT_VALID   : sorter presents an index this cycle
//   EVT_ADDR    : index to transmit
//   NEW_IMAGE   : one-cycle pulse, restarts the per-image sent count
//   CTRL_BUSY   : back-pressure to the sorter
//   AEROUT_ADDR : AER address bus, stable while a handshake is in flight
//   AEROUT_REQ  : AER request
//   AEROUT_ACK  : AER acknowledge, asynchronous to CLK
//   IMAGE_SENT  : IMAGE_SIZE events handshaken since the last NEW_IMAGE
//   OVERFLOW    : sticky, an event arrived while the FIFO was full
module aer_spike_out
  import snn_aer_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = AER_ADDR_BITS,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = AER_SYNC_STAGES,
  parameter int unsigned IMAGE_SIZE  = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EVT_VALID,
  input  logic [ADDR_BITS-1:0] EVT_ADDR,
  input  logic                 NEW_IMAGE,
  output logic                 CTRL_BUSY,
  output logic [ADDR_BITS-1:0] AEROUT_ADDR,
  output logic                 AEROUT_REQ,
  input  logic                 AEROUT_ACK,
  output logic                 IMAGE_SENT,
  output logic                 OVERFLOW
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SentW = $clog2(IMAGE_SIZE + 1);

  // FIFO
  logic [ADDR_BITS-1:0] fifo_head;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  aer_event_fifo #(
    .WIDTH (ADDR_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (EVT_VALID),
    .pop   (fifo_pop),
    .wdata (EVT_ADDR),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One slot of margin: the sorter's valid is registered and lags its view of BUSY.
  assign CTRL_BUSY = (fifo_count >= CntW'(FIFO_DEPTH - 1));

  // ACK synchronizer
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q[0] <= AEROUT_ACK;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Handshake FSM
  aer_state_t           state_q, state_d;
  logic                 req_q, req_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 hs_done;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fifo_pop = 1'b0;
    hs_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Waiting for ack_s low keeps a late ACK from being taken for the next event.
        if (!fifo_empty && !ack_s) begin
          addr_d   = fifo_head;
          fifo_pop = 1'b1;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!ack_s) begin
          hs_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign AEROUT_REQ  = req_q;
  assign AEROUT_ADDR = addr_q;

  // Per-image sent counter and sticky overflow
  logic [SentW-1:0] sent_q, sent_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    sent_d = sent_q;
    // NEW_IMAGE takes priority over a completion landing in the same cycle.
    if (NEW_IMAGE) begin
      sent_d = '0;
    end else if (hs_done && (sent_q != SentW'(IMAGE_SIZE))) begin
      sent_d = sent_q + SentW'(1);
    end
  end

  // A pop in the same cycle makes room, so only an unrelieved full drops the event.
  assign ovf_d = ovf_q | (EVT_VALID && fifo_full && !fifo_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sent_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sent_q <= sent_d;
      ovf_q  <= ovf_d;
    end
  end

  assign IMAGE_SENT = (sent_q == SentW'(IMAGE_SIZE));
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_aer_spike_out.sv
module tb_aer_spike_out;

  localparam int unsigned AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EVT_VALID;
  logic [AW-1:0] EVT_ADDR;
  logic          NEW_IMAGE;
  logic          CTRL_BUSY;
  logic [AW-1:0] AEROUT_ADDR;
  logic          AEROUT_REQ;
  logic          AEROUT_ACK;
  logic          IMAGE_SENT;
  logic          OVERFLOW;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] sb[$];

  aer_spike_out #(
    .ADDR_BITS   (AW),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2),
    .IMAGE_SIZE  (5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EVT_VALID   (EVT_VALID),
    .EVT_ADDR    (EVT_ADDR),
    .NEW_IMAGE   (NEW_IMAGE),
    .CTRL_BUSY   (CTRL_BUSY),
    .AEROUT_ADDR (AEROUT_ADDR),
    .AEROUT_REQ  (AEROUT_REQ),
    .AEROUT_ACK  (AEROUT_ACK),
    .IMAGE_SENT  (IMAGE_SENT),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Receiver: manual level, or auto-ack after ack_dly and release after rel_dly negedges.
  bit rx_auto  = 1'b0;
  bit rx_force = 1'b0;
  int ack_dly  = 2;
  int rel_dly  = 2;

  initial begin
    int rx_cnt;
    AEROUT_ACK = 1'b0;
    rx_cnt     = 0;
    forever begin
      @(negedge CLK);
      if (!rx_auto) begin
        AEROUT_ACK = rx_force;
        rx_cnt     = 0;
      end else if (AEROUT_REQ != AEROUT_ACK) begin
        rx_cnt++;
        if (rx_cnt >= (AEROUT_REQ ? ack_dly : rel_dly)) begin
          AEROUT_ACK = AEROUT_REQ;
          rx_cnt     = 0;
        end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  // Monitor: each REQ rise pops the scoreboard; address must hold while REQ is high.
  logic          req_prev = 1'b0;
  logic [AW-1:0] held_addr = '0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (AEROUT_REQ && !req_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_req", 32'(AEROUT_ADDR), 32'hFFFF_FFFF);
        end else begin
          check("req_addr", 32'(AEROUT_ADDR), 32'(sb.pop_front()));
        end
        held_addr = AEROUT_ADDR;
      end else if (AEROUT_REQ) begin
        check("addr_stable", 32'(AEROUT_ADDR), 32'(held_addr));
      end
    end
    req_prev = AEROUT_REQ;
  end

  task automatic send(input logic [AW-1:0] a);
    EVT_VALID = 1'b1;
    EVT_ADDR  = a;
    sb.push_back(a);
    tick();
    EVT_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || AEROUT_REQ || AEROUT_ACK) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n < 400), 32'd1);
    repeat (6) tick();
  endtask

  task automatic new_image_pulse();
    NEW_IMAGE = 1'b1;
    tick();
    NEW_IMAGE = 1'b0;
    check("new_image_clears", 32'(IMAGE_SENT), 32'd0);
  endtask

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic          acc;
    logic          exp_busy;
    logic          exp_ovf;
    logic          exp_req;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Receiver stalled with ACK low; one event leaves at the second edge.
    tbl[0] = '{1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};

    RST       = 1'b1;
    EVT_VALID = 1'b0;
    EVT_ADDR  = '0;
    NEW_IMAGE = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(CTRL_BUSY), 32'd0);
    check("rst_addr", 32'(AEROUT_ADDR), 32'd0);
    check("rst_req", 32'(AEROUT_REQ), 32'd0);
    check("rst_image_sent", 32'(IMAGE_SENT), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    RST = 1'b0;
    tick();

    // Basic ordered transmission
    rx_auto = 1'b1;
    send(8'd3);
    send(8'd1);
    send(8'd4);
    wait_idle("seq314");
    check("sent3_not_image", 32'(IMAGE_SENT), 32'd0);
    send(8'd5);
    send(8'd9);
    wait_idle("seq5");
    check("image_sent_after5", 32'(IMAGE_SENT), 32'd1);
    check("busy_idle", 32'(CTRL_BUSY), 32'd0);
    new_image_pulse();

    // NEW_IMAGE landing on the completion edge of one handshake
    send(8'h07);
    n = 0;
    while (!(AEROUT_ACK && !AEROUT_REQ) && n < 100) begin tick(); n++; end
    while (AEROUT_ACK && n < 100) begin tick(); n++; end
    check("coinc_sync_timeout", 32'(n < 100), 32'd1);
    tick();
    NEW_IMAGE = 1'b1;
    tick();
    NEW_IMAGE = 1'b0;
    wait_idle("coinc");
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
    wait_idle("coinc4");
    check("coinc_count_zero", 32'(IMAGE_SENT), 32'd0);
    send(8'h44);
    wait_idle("coinc5");
    check("coinc_image_sent", 32'(IMAGE_SENT), 32'd1);
    new_image_pulse();

    // Back-pressure and overflow with a stalled receiver
    rx_auto  = 1'b0;
    rx_force = 1'b0;
    for (int i = 0; i < 7; i++) begin
      EVT_VALID = tbl[i].valid;
      EVT_ADDR  = tbl[i].addr;
      if (tbl[i].valid && tbl[i].acc) sb.push_back(tbl[i].addr);
      tick();
      check($sformatf("stall_busy_%0d", i), 32'(CTRL_BUSY), 32'(tbl[i].exp_busy));
      check($sformatf("stall_ovf_%0d", i), 32'(OVERFLOW), 32'(tbl[i].exp_ovf));
      check($sformatf("stall_req_%0d", i), 32'(AEROUT_REQ), 32'(tbl[i].exp_req));
    end
    EVT_VALID = 1'b0;
    repeat (10) tick();
    check("stall_req_held", 32'(AEROUT_REQ), 32'd1);
    check("stall_addr_held", 32'(AEROUT_ADDR), 32'h10);
    rx_auto = 1'b1;
    wait_idle("stall");
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);
    check("busy_drained", 32'(CTRL_BUSY), 32'd0);
    check("stall_image_sent", 32'(IMAGE_SENT), 32'd1);

    // ACK still high when the FIFO becomes non-empty
    rx_auto  = 1'b0;
    rx_force = 1'b1;
    repeat (4) tick();
    send(8'h2A);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("ack_high_no_req_%0d", i), 32'(AEROUT_REQ), 32'd0);
    end
    rx_force = 1'b0;
    tick();
    tick();
    check("ack_low_sync_req", 32'(AEROUT_REQ), 32'd0);
    tick();
    check("ack_low_req_rise", 32'(AEROUT_REQ), 32'd1);
    rx_auto = 1'b1;
    wait_idle("ack_high");

    // Reset mid-handshake with two events queued
    rx_auto  = 1'b0;
    rx_force = 1'b0;
    send(8'h21);
    send(8'h22);
    send(8'h23);
    check("pre_rst_req", 32'(AEROUT_REQ), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_req", 32'(AEROUT_REQ), 32'd0);
    check("rst_mid_busy", 32'(CTRL_BUSY), 32'd0);
    check("rst_mid_ovf", 32'(OVERFLOW), 32'd0);
    check("rst_mid_image", 32'(IMAGE_SENT), 32'd0);
    sb.delete();
    tick();
    tick();
    RST = 1'b0;
    repeat (10) tick();
    check("post_rst_no_req", 32'(AEROUT_REQ), 32'd0);
    check("post_rst_busy", 32'(CTRL_BUSY), 32'd0);
    rx_auto = 1'b1;
    send(8'h5C);
    wait_idle("post_rst");
    check("post_rst_image", 32'(IMAGE_SENT), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
